// File: rtl/cs_result_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cs_result_fifo : FWFT buffer for CS results, discards the warm-up window.
// Optional min/max tracking: define CS_RESULT_MINMAX_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module cs_result_fifo #(
   parameter int DEPTH  = 16,
   parameter int WARMUP = 9
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     in_en,
   input  logic [9:0]               Y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [9:0]               out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     warm,
   output logic                     overflow,
   output logic [9:0]               y_min,
   output logic [9:0]               y_max
);

   localparam int              AW       = $clog2(DEPTH);
   localparam int              CW       = $clog2(WARMUP + 1);
   localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0]   WARM_CNT = CW'(WARMUP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   wcnt_q, wcnt_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [9:0]      mem_q [DEPTH];
   logic [9:0]      mem_d [DEPTH];
   logic            pop, push, drop;

   always_comb begin
      out_valid = (count_q != '0);
      full      = (count_q == FULL_CNT);
      warm      = (state_q == RUN);
      pop       = out_valid && out_ready;
      push      = in_en && warm && (!full || pop);
      drop      = in_en && warm && full && !pop;
   end

   assign out_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      mem_d      = mem_q;
      if (clr) begin
         state_d    = IDLE;
         wcnt_d     = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      end else begin
         // The strobe that completes the window is consumed while still in FILL,
         // so it never becomes a write candidate.
         case (state_q)
            IDLE: if (in_en) begin
               wcnt_d  = CW'(1);
               state_d = (WARM_CNT <= CW'(1)) ? RUN : FILL;
            end
            FILL: if (in_en) begin
               if (wcnt_q != WARM_CNT) wcnt_d = wcnt_q + 1'b1;
               if (CW'(wcnt_q + 1'b1) == WARM_CNT) state_d = RUN;
            end
            default: ;
         endcase
         if (push) begin
            mem_d[wr_ptr_q] = Y;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
         endcase
         if (drop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

`ifdef CS_RESULT_MINMAX_EN
   logic [9:0] y_min_q, y_min_d, y_max_q, y_max_d;

   // Only accepted samples count; dropped and warm-up samples are ignored.
   always_comb begin
      y_min_d = y_min_q;
      y_max_d = y_max_q;
      if (clr) begin
         y_min_d = 10'h3FF;
         y_max_d = 10'h000;
      end else if (push) begin
         if (Y < y_min_q) y_min_d = Y;
         if (Y > y_max_q) y_max_d = Y;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_min_q <= 10'h3FF;
         y_max_q <= 10'h000;
      end else begin
         y_min_q <= y_min_d;
         y_max_q <= y_max_d;
      end
   end

   assign y_min = y_min_q;
   assign y_max = y_max_q;
`else
   assign y_min = 10'h3FF;
   assign y_max = 10'h000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cs_result_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cs_result_fifo : directed stimulus with a queue scoreboard and monitor.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cs_result_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr = 1'b0;
   logic       in_en = 1'b0;
   logic [9:0] Y = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [9:0] out_data;
   logic [4:0] count;
   logic       full, warm, overflow;
   logic [9:0] y_min, y_max;

   int vectors = 0;
   int miscompares = 0;
   logic [9:0] exp_q [$];

   cs_result_fifo #(.DEPTH(16), .WARMUP(9)) dut (
      .clk(clk), .reset(reset), .clr(clr), .in_en(in_en), .Y(Y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .full(full), .warm(warm), .overflow(overflow),
      .y_min(y_min), .y_max(y_max)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: inputs are stable at the falling edge; a pop completes at the next rising edge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pop_unexpected: got %0d, expected no data", out_data);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               miscompares++;
               $display("FAIL pop_data: got %0d, expected %0d (t=%0t)", out_data, e, $time);
            end
         end
      end
   end

   // Drives one cycle starting at posedge+2; 'wr' says whether the bench expects a write.
   task automatic cyc(input logic en, input int y, input logic rdy, input logic wr);
      in_en = en;
      Y = 10'(y);
      out_ready = rdy;
      if (wr) exp_q.push_back(10'(y));
      @(posedge clk); #2;
      in_en = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #2;
      reset = 1'b0;
   endtask

   task automatic warmup();
      for (int i = 0; i < 9; i++) cyc(1'b1, 0, 1'b0, 1'b0);
   endtask

   task automatic chk_minmax_idle(input string nm);
      chk({nm, "_ymin"}, y_min, 10'h3FF);
      chk({nm, "_ymax"}, y_max, 10'h000);
   endtask

   initial begin
      @(posedge clk); #2;
      chk("rst_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_warm", warm, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_data", out_data, 0);
      chk_minmax_idle("rst");
      reset = 1'b0;

      // Warm-up: strobes 1..12, the first nine discarded.
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b1, i, 1'b0, i >= 10);
         if (i == 8) chk("warm_after8", warm, 0);
         if (i == 9) chk("warm_after9", warm, 1);
         if (i == 9) chk("count_after9", count, 0);
      end
      chk("wu_count", count, 3);
      chk("wu_valid", out_valid, 1);
      chk("wu_head", out_data, 10);
      for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b0);
      chk("wu_drained", count, 0);
      chk("wu_empty", out_valid, 0);

      // Fill to full and overflow.
      do_reset();
      warmup();
      for (int i = 0; i <= 16; i++) begin
         cyc(1'b1, 100 + i, 1'b0, i < 16);
         if (i == 14) chk("full_early", full, 0);
         if (i == 15) begin
            chk("full_at115", full, 1);
            chk("ovf_at115", overflow, 0);
         end
      end
      chk("ovf_set", overflow, 1);
      chk("ovf_count", count, 16);
      chk("ovf_full", full, 1);

      // Push and pop together while full.
      cyc(1'b1, 200, 1'b1, 1'b1);
      chk("pp_count", count, 16);
      chk("pp_ovf", overflow, 1);
      chk("pp_head", out_data, 101);

      // Stream 20 values through a full FIFO, then drain across the wrap.
      for (int i = 0; i < 20; i++) cyc(1'b1, 300 + i, 1'b1, 1'b1);
      chk("stream_count", count, 16);
      for (int i = 0; i < 16; i++) cyc(1'b0, 0, 1'b1, 1'b0);
      chk("drain_count", count, 0);
      chk("drain_valid", out_valid, 0);
      chk("drain_sb", exp_q.size(), 0);

      // Asynchronous reset between edges with five entries buffered.
      for (int i = 0; i < 5; i++) cyc(1'b1, 400 + i, 1'b0, 1'b1);
      chk("pre_rst_count", count, 5);
      #1 reset = 1'b1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_warm", warm, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_full", full, 0);
      exp_q.delete();
      @(posedge clk); #2;
      reset = 1'b0;

      // Synchronous clear together with a strobe.
      warmup();
      for (int i = 0; i < 3; i++) cyc(1'b1, 450 + i, 1'b0, 1'b1);
      exp_q.delete();
      clr = 1'b1;
      cyc(1'b1, 500, 1'b0, 1'b0);
      clr = 1'b0;
      chk("clr_count", count, 0);
      chk("clr_valid", out_valid, 0);
      chk("clr_warm", warm, 0);
      chk("clr_data", out_data, 0);
      cyc(1'b1, 7, 1'b0, 1'b0);
      chk("clr_refill_warm", warm, 0);
      chk("clr_refill_count", count, 0);

      // Min/max tracking, including a dropped zero.
      do_reset();
      warmup();
      cyc(1'b1, 300, 1'b0, 1'b1);
      cyc(1'b1, 50, 1'b0, 1'b1);
      cyc(1'b1, 573, 1'b0, 1'b1);
`ifdef CS_RESULT_MINMAX_EN
      chk("mm_min", y_min, 50);
      chk("mm_max", y_max, 573);
`else
      chk_minmax_idle("mm_off");
`endif
      for (int i = 0; i < 13; i++) cyc(1'b1, 100, 1'b0, 1'b1);
      chk("mm_full", full, 1);
      cyc(1'b1, 0, 1'b0, 1'b0);
      chk("mm_drop_ovf", overflow, 1);
`ifdef CS_RESULT_MINMAX_EN
      chk("mm_min_drop", y_min, 50);
      chk("mm_max_drop", y_max, 573);
`else
      chk_minmax_idle("mm_off_drop");
`endif
      for (int i = 0; i < 16; i++) cyc(1'b0, 0, 1'b1, 1'b0);
      chk("final_count", count, 0);
      chk("final_sb", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cs_result_fifo.md
# cs_result_fifo

Downstream consumer of the computational-system (CS) stage. It captures the 10-bit CS result `Y` on each sample strobe and discards results produced before the 9-sample window is full. Valid results are buffered in a small first-word-fall-through FIFO and delivered to the next stage over a valid/ready handshake. It also reports occupancy and a sticky overflow flag.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `WARMUP`, default 9: number of initial strobes discarded (window fill).
- `clk` input 1: single clock; all state is updated on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `clr` input 1: synchronous clear; same effect as reset, on the next rising edge.
- `in_en` input 1: high for one cycle per new sample consumed by CS.
- `Y` input 10: CS result. CS drives it on the falling edge, so it is stable at the rising edge.
- `out_valid` output 1: the head entry is available.
- `out_ready` input 1: downstream accepts the head entry.
- `out_data` output 10: head entry; held stable while `out_valid && !out_ready`.
- `count` output log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full` output 1: `count == DEPTH`.
- `warm` output 1: the warm-up period is complete.
- `overflow` output 1: sticky; a valid sample was dropped.
- `y_min` output 10: minimum of the written samples (see Configuration).
- `y_max` output 10: maximum of the written samples (see Configuration).

## Operation
- Control FSM states:
  - IDLE: after reset or `clr`. The first `in_en` moves the FSM to FILL, and that strobe counts as warm-up strobe 1.
  - FILL: counts `in_en` strobes. When the counter reaches `WARMUP`, move to RUN. The strobe that reaches `WARMUP` is itself discarded.
  - RUN: `warm` = 1. Every `in_en` is a write candidate. The FSM stays in RUN until reset or `clr`.
- Warm-up counter: width ceil(log2(WARMUP+1)); saturates and never wraps.
- Pop: `pop = out_valid && out_ready`.
- Write when `in_en && warm && (!full || pop)`. Simultaneous push and pop while full is legal: `count` stays at DEPTH and both pointers advance.
- Drop when `in_en && warm && full && !pop`: the sample is discarded and `overflow` is set. `overflow` clears only on reset or `clr`.
- Push and pop in the same cycle with `count == 0`: not possible, since `out_valid` = 0; the push takes effect normally.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately.
- `out_data` = `mem[rd_ptr]` (combinational read of registered storage). It is undefined when `out_valid` = 0, and the bench must not check it then.
- `Y` range: CS guarantees ≤ 573 ((2·9·255)>>3). The block stores all 10 bits without checking.
- `clr` has priority over a simultaneous `in_en` or pop; both are ignored that cycle.

## Timing
- Reset values:
  - `out_valid` = 0, `count` = 0, `full` = 0, `warm` = 0, `overflow` = 0.
  - `out_data` = 0 (memory entry 0 cleared).
  - `y_min` = 10'h3FF, `y_max` = 10'h000.
  - FSM = IDLE, pointers = 0.
- Reset mid-operation discards all buffered data immediately, because it is asynchronous.
- Write latency: a sample written at edge N is visible on `out_data`/`out_valid` after edge N, i.e. in cycle N+1.
- Pop: takes effect at the edge where `out_valid && out_ready`; the next entry appears in the following cycle.
- `warm` rises after the edge that consumes strobe `WARMUP`. The first sample written is from strobe `WARMUP+1`.
- `count`, `full` and `overflow` are registered and update at the same edge as the push or pop that changes them.

## Configuration
- Macro: `CS_RESULT_MINMAX_EN`.
- Defined:
  - `y_min` and `y_max` update at each write, i.e. on accepted samples only; dropped and discarded samples never update them.
  - Rule: `y_min` ← min(`y_min`, `Y`); `y_max` ← max(`y_max`, `Y`).
  - Reset and `clr` restore 3FF and 000.
- Undefined: the tracking logic is not built. `y_min` is tied to 10'h3FF and `y_max` to 10'h000; the ports remain.

## Test plan
- Warm-up: 12 strobes with `Y` = 1..12 and `out_ready` = 0 → `warm` rises after strobe 9; `count` = 3; `out_data` = 10; entries are 10, 11, 12.
- Fill/overflow (DEPTH = 16): 9 warm-up strobes, then 17 strobes with `Y` = 100..116 and `out_ready` = 0 → `full` = 1 after `Y` = 115; `Y` = 116 is dropped; `overflow` = 1; `count` = 16.
- Full with simultaneous push and pop: from full, drive `in_en` with `Y` = 200 and `out_ready` = 1 in the same cycle → `count` stays 16, the head advances, and 200 is the tail; `overflow` is unchanged.
- Drain with wrap-around: after a full/drain cycle, push 20 values and pop continuously → output order equals input order across the pointer wrap; `count` returns to 0 and `out_valid` = 0.
- Reset and clear mid-operation: assert `reset` asynchronously between edges with `count` = 5 → all outputs go to their reset values immediately. Repeat with `clr` together with `in_en` → the sample is ignored and the FSM returns to IDLE.
- `CS_RESULT_MINMAX_EN` defined: write 300, 50, 573 after warm-up → `y_min` = 50, `y_max` = 573; a dropped sample of 0 leaves `y_min` = 50. With the macro undefined: `y_min` = 3FF and `y_max` = 0 throughout.
